// File: rtl/serial_sub_ctrl_pkg.sv
// Shared definitions for the bit-serial subtractor: state encoding, default width
// and the counter-width helper.
package sub_pkg;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_RUN  = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   localparam int SUB_WIDTH = 8;

   // Bits needed to count 0..v-1; never less than one bit.
   function automatic int clog2(input int v);
      int r;
      r = 0;
      while ((1 << r) < v) r++;
      if (r == 0) r = 1;
      return r;
   endfunction

endpackage

// File: rtl/serial_sub_ctrl_if.sv
// Request/result bundle between a requester and the serial subtractor.
interface serial_sub_ctrl_if
   import sub_pkg::*;
#(
   parameter int WIDTH = SUB_WIDTH
);
   // start is taken only on a rising edge where ready=1; a, b and bin are sampled on
   // that edge. done pulses for one cycle when diff/bout become valid, and they hold
   // until the next accepted start.
   logic             start;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             bin;
   logic             ready;
   logic [WIDTH-1:0] diff;
   logic             bout;
   logic             done;

   modport master (output start, a, b, bin, input ready, diff, bout, done);
   modport slave  (input start, a, b, bin, output ready, diff, bout, done);
endinterface

// File: rtl/subtraction.sv
// Combinational 1-bit full subtractor: D = A - B - cin, cout = borrow out.
module subtraction (
   input  logic A,
   input  logic B,
   input  logic cin,
   output logic D,
   output logic cout
);
   assign D    = A ^ B ^ cin;
   assign cout = (~A & B) | (~A & cin) | (B & cin);
endmodule

// File: rtl/serial_sub_ctrl.sv
// Sequential driver that feeds the 1-bit subtractor LSB-first, one bit per clock,
// and reports the WIDTH-bit difference and final borrow with a start/ready/done handshake.
module serial_sub_ctrl
   import sub_pkg::*;
#(
   parameter int WIDTH = SUB_WIDTH
) (
   input  logic                clk,
   input  logic                rst,
   serial_sub_ctrl_if.slave    bus,
   output logic [1:0]          state_dbg
);

   localparam int              CW   = clog2(WIDTH);
   localparam logic [CW-1:0]   LAST = CW'(WIDTH - 1);

   logic [1:0]       state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0] a_sh_q, a_sh_d;
   logic [WIDTH-1:0] b_sh_q, b_sh_d;
   logic [WIDTH-1:0] res_sh_q, res_sh_d;
   logic             brw_q, brw_d;
   logic [WIDTH-1:0] diff_q, diff_d;
   logic             bout_q, bout_d;

   logic             cell_d;
   logic             cell_cout;

   subtraction u_cell (
      .A    (a_sh_q[0]),
      .B    (b_sh_q[0]),
      .cin  (brw_q),
      .D    (cell_d),
      .cout (cell_cout)
   );

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      a_sh_d   = a_sh_q;
      b_sh_d   = b_sh_q;
      res_sh_d = res_sh_q;
      brw_d    = brw_q;
      diff_d   = diff_q;
      bout_d   = bout_q;
      case (state_q)
         S_IDLE: begin
            if (bus.start) begin
               state_d = S_RUN;
               a_sh_d  = bus.a;
               b_sh_d  = bus.b;
               brw_d   = bus.bin;
               cnt_d   = '0;
            end
         end
         S_RUN: begin
            a_sh_d   = a_sh_q >> 1;
            b_sh_d   = b_sh_q >> 1;
            res_sh_d = {cell_d, res_sh_q[WIDTH-1:1]};
            brw_d    = cell_cout;
            cnt_d    = cnt_q + 1'b1;
            // The last bit's D/cout go straight into the visible result.
            if (cnt_q == LAST) begin
               state_d = S_DONE;
               cnt_d   = '0;
               diff_d  = res_sh_d;
               bout_d  = cell_cout;
            end
         end
         S_DONE: state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= S_IDLE;
         cnt_q    <= '0;
         a_sh_q   <= '0;
         b_sh_q   <= '0;
         res_sh_q <= '0;
         brw_q    <= 1'b0;
         diff_q   <= '0;
         bout_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         a_sh_q   <= a_sh_d;
         b_sh_q   <= b_sh_d;
         res_sh_q <= res_sh_d;
         brw_q    <= brw_d;
         diff_q   <= diff_d;
         bout_q   <= bout_d;
      end
   end

   assign bus.ready = (state_q == S_IDLE);
   assign bus.done  = (state_q == S_DONE);
   assign bus.diff  = diff_q;
   assign bus.bout  = bout_q;
   assign state_dbg = state_q;

endmodule
